// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-entry busy scoreboard and a post-reset clear sweep.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    input  logic            i_write_en,
    input  logic [AW-1:0]   i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    input  logic            i_issue_en,
    input  logic [AW-1:0]   i_issue_addr,
    output logic            o_ready
);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [NREG-1:0] r_busy;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_run, w_we, w_iss, w_hit1, w_hit2, w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_data;

    assign w_run      = (r_state == RUN) && !i_rst;
    assign w_we       = w_run && i_write_en && i_rd_addr != '0;
    assign w_iss      = w_run && i_issue_en && i_issue_addr != '0;
    assign w_hit1     = BYPASS != 0 && w_we && i_rd_addr == i_rs1_addr;
    assign w_hit2     = BYPASS != 0 && w_we && i_rd_addr == i_rs2_addr;
    // The sweep and writeback share one write port; the sweep owns it outside RUN.
    assign w_mem_we   = !i_rst && (r_state == CLEAR || w_we);
    assign w_mem_addr = r_state == RUN ? i_rd_addr : r_cnt;
    assign w_mem_data = r_state == RUN ? i_rd_data : '0;

    always_ff @(posedge i_clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(1);
            r_busy  <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= r_cnt == LAST ? RUN : CLEAR;
        end else begin
            if (w_we)
                r_busy[i_rd_addr] <= 1'b0;
            if (w_iss)
                r_busy[i_issue_addr] <= 1'b1;
        end
    end

    assign o_ready    = w_run;
    assign o_rs1_data = (!w_run || i_rs1_addr == '0) ? '0 : w_hit1 ? i_rd_data : r_mem[i_rs1_addr];
    assign o_rs2_data = (!w_run || i_rs2_addr == '0) ? '0 : w_hit2 ? i_rd_data : r_mem[i_rs2_addr];
    assign o_rs1_busy = w_run && i_rs1_addr != '0 && !w_hit1 && r_busy[i_rs1_addr];
    assign o_rs2_busy = w_run && i_rs2_addr != '0 && !w_hit2 && r_busy[i_rs2_addr];
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports i_rs1_addr, i_rs2_addr  in  AW  read addresses.
REQ-007 SHALL have ports o_rs1_data, o_rs2_data  out  XLEN  combinational read data.
REQ-008 SHALL have ports o_rs1_busy, o_rs2_busy  out  1  source has an outstanding producer.
REQ-009 SHALL have port i_write_en  in  1  writeback strobe.
REQ-010 SHALL have ports i_rd_addr  in  AW, i_rd_data  in  XLEN  writeback address/data.
REQ-011 SHALL have port i_issue_en  in  1  instruction with destination issued this cycle.
REQ-012 SHALL have port i_issue_addr  in  AW  destination of issued instruction.
REQ-013 SHALL have port o_ready  out  1  clear sequence complete, block accepts traffic.

Function
REQ-014 SHALL hold NREG-1 storage entries (1..NREG-1); address 0 SHALL read 0, never be busy, ignore writes/issues.
REQ-015 SHALL implement two states: CLEAR (o_ready=0) and RUN (o_ready=1).
REQ-016 CLEAR: AW-bit counter starts at 1, zeroes one entry per cycle, increments; after writing NREG-1 SHALL enter RUN next cycle (NREG-1 cycles of CLEAR after reset deasserts).
REQ-017 In CLEAR, i_write_en and i_issue_en SHALL be ignored; o_rsN_data SHALL be 0 and o_rsN_busy 0.
REQ-018 In RUN, i_write_en=1 with i_rd_addr!=0 SHALL write i_rd_data into entry i_rd_addr at the clock edge.
REQ-019 Busy bit per entry: set on i_issue_en with i_issue_addr!=0; cleared on i_write_en to that address.
REQ-020 Simultaneous issue and write to the same address SHALL leave busy set (new producer wins); data still written.
REQ-021 Issue to an already-busy address SHALL keep busy set (no count, single outstanding producer tracked).
REQ-022 Reads are combinational, zero latency; data visible from cycle after write when BYPASS=0.
REQ-023 BYPASS=1: if i_write_en, i_rd_addr!=0 and i_rd_addr==i_rsN_addr, o_rsN_data SHALL be i_rd_data and o_rsN_busy SHALL be 0 unless same-cycle issue to that address also sets it (busy output reflects stored bit only, not the same-cycle issue).
REQ-024 BYPASS=0: o_rsN_data SHALL be stored value, o_rsN_busy stored busy bit.
REQ-025 rs1 and rs2 ports SHALL be fully independent; both may address the same entry.
REQ-026 Issue does not appear in o_rsN_busy until the following cycle.

Reset
REQ-027 i_rst=1 at a rising edge SHALL force state CLEAR, counter=1, all busy bits 0, o_ready=0 on next cycle.
REQ-028 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full clear sequence; in-flight writes that cycle SHALL be dropped.
REQ-029 While i_rst=1 outputs SHALL be: o_ready=0, o_rsN_data=0, o_rsN_busy=0.
REQ-030 Entries SHALL NOT be cleared in a single cycle; only the CLEAR sweep zeroes them.

Verification
REQ-031 Reset 1 cycle, NREG=32 -> o_ready rises exactly 31 cycles after i_rst falls; all 31 entries read 0.
REQ-032 RUN: write x5=0xDEADBEEF, BYPASS=1, rs1=5 same cycle -> o_rs1_data=0xDEADBEEF that cycle; BYPASS=0 -> old value 0, new value next cycle.
REQ-033 Issue x7, then rs2=7 -> busy=1 next cycle; write x7=0x12 -> (BYPASS=1) busy=0 and data 0x12 same cycle, stored busy 0 after.
REQ-034 Same cycle issue x9 and write x9=0x55 -> next cycle x9 reads 0x55 and busy=1.
REQ-035 Write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, busy 0 forever.
REQ-036 Reset asserted with x3 busy and value 0x77 in RUN -> busy 0, o_ready 0, x3 reads 0 after sweep; writes during CLEAR leave entries 0.
